mux_seq_driver: RTL and testbench

MUX_SEQ_DRIVER -- requirements
Module: mux_seq_driver

---
 rtl/mux_seq_driver.sv | 171 +++++++++++++++++
 tb/tb_mux_seq_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_seq_driver.sv
// Drives a downstream 2:1 mux through a select-0 / select-1 dwell sequence,
// samples its output in each phase and flags any mismatch. One pending
// request can be queued while a run is in progress.
module mux_seq_driver #(
    parameter int unsigned DWELL = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic d0,
    input  logic d1,
    output logic ready,
    output logic s,
    output logic i0,
    output logic i1,
    input  logic mux_out,
    output logic busy,
    output logic done,
    output logic y0,
    output logic y1,
    output logic err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PHASE0 = 2'd1,
        ST_PHASE1 = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_pd0,   w_pd0_nxt;
    logic             r_pd1,   w_pd1_nxt;
    logic             r_pend,  w_pend_nxt;
    logic             r_s,     w_s_nxt;
    logic             r_i0,    w_i0_nxt;
    logic             r_i1,    w_i1_nxt;
    logic             r_y0,    w_y0_nxt;
    logic             r_y1,    w_y1_nxt;
    logic             r_err,   w_err_nxt;

    logic w_ready;
    logic w_accept;
    logic w_mis0;
    logic w_mis1;

    // Handshake decoded from registers only
    assign w_ready  = (r_state == ST_IDLE) || !r_pend;
    assign w_accept = load && w_ready;
    // Four-state compare so an undriven or unknown mux output is a mismatch
    assign w_mis0   = (mux_out !== r_i0);
    assign w_mis1   = (mux_out !== r_i1);

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pd0_nxt   = r_pd0;
        w_pd1_nxt   = r_pd1;
        w_pend_nxt  = r_pend;
        w_s_nxt     = r_s;
        w_i0_nxt    = r_i0;
        w_i1_nxt    = r_i1;
        w_y0_nxt    = r_y0;
        w_y1_nxt    = r_y1;
        w_err_nxt   = r_err;

        unique case (r_state)
            ST_IDLE: begin
                w_s_nxt = 1'b0;
                if (w_accept) begin
                    w_i0_nxt    = d0;
                    w_i1_nxt    = d1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PHASE0;
                end
            end
            ST_PHASE0, ST_PHASE1: begin
                if (w_accept) begin
                    w_pd0_nxt  = d0;
                    w_pd1_nxt  = d1;
                    w_pend_nxt = 1'b1;
                end
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (r_state == ST_PHASE0) begin
                        w_y0_nxt    = mux_out;
                        w_err_nxt   = r_err | w_mis0;
                        w_s_nxt     = 1'b1;
                        w_state_nxt = ST_PHASE1;
                    end else begin
                        w_y1_nxt    = mux_out;
                        w_err_nxt   = r_err | w_mis1;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_cnt_nxt = '0;
                if (r_pend) begin
                    // Back-to-back run from the pending buffer
                    w_i0_nxt    = r_pd0;
                    w_i1_nxt    = r_pd1;
                    w_pend_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_s_nxt     = 1'b0;
                    w_state_nxt = ST_PHASE0;
                end else if (w_accept) begin
                    w_i0_nxt    = d0;
                    w_i1_nxt    = d1;
                    w_err_nxt   = 1'b0;
                    w_s_nxt     = 1'b0;
                    w_state_nxt = ST_PHASE0;
                end else begin
                    w_s_nxt     = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pd0   <= 1'b0;
            r_pd1   <= 1'b0;
            r_pend  <= 1'b0;
            r_s     <= 1'b0;
            r_i0    <= 1'b0;
            r_i1    <= 1'b0;
            r_y0    <= 1'b0;
            r_y1    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pd0   <= w_pd0_nxt;
            r_pd1   <= w_pd1_nxt;
            r_pend  <= w_pend_nxt;
            r_s     <= w_s_nxt;
            r_i0    <= w_i0_nxt;
            r_i1    <= w_i1_nxt;
            r_y0    <= w_y0_nxt;
            r_y1    <= w_y1_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign ready = w_ready;
    assign s     = r_s;
    assign i0    = r_i0;
    assign i1    = r_i1;
    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign y0    = r_y0;
    assign y1    = r_y1;
    assign err   = r_err;

endmodule

// File: tb/tb_mux_seq_driver.sv
// Directed bench for mux_seq_driver: DWELL=5 instance plus a DWELL=1 instance.
`timescale 1ns/1ps
module tb_mux_seq_driver;

    logic clock;
    logic reset;

    // DWELL=5 instance
    logic load, d0, d1, mux_out, tie0;
    logic ready, s, i0, i1, busy, done, y0, y1, err;

    // DWELL=1 instance
    logic load_1, d0_1, d1_1, mux_out_1;
    logic ready_1, s_1, i0_1, i1_1, busy_1, done_1, y0_1, y1_1, err_1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    mux_seq_driver #(.DWELL(5)) dut (
        .clock(clock), .reset(reset), .load(load), .d0(d0), .d1(d1),
        .ready(ready), .s(s), .i0(i0), .i1(i1), .mux_out(mux_out),
        .busy(busy), .done(done), .y0(y0), .y1(y1), .err(err)
    );

    mux_seq_driver #(.DWELL(1)) dut1 (
        .clock(clock), .reset(reset), .load(load_1), .d0(d0_1), .d1(d1_1),
        .ready(ready_1), .s(s_1), .i0(i0_1), .i1(i1_1), .mux_out(mux_out_1),
        .busy(busy_1), .done(done_1), .y0(y0_1), .y1(y1_1), .err(err_1)
    );

    // Downstream 2:1 mux models; tie0 forces a stuck-at-0 output
    assign mux_out   = tie0 ? 1'b0 : (s ? i1 : i0);
    assign mux_out_1 = s_1 ? i1_1 : i0_1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        int n_busy;
        int lat;
        logic exp_s;

        reset = 1'b1; tie0 = 1'b0;
        load = 1'b0; d0 = 1'b0; d1 = 1'b0;
        load_1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0;
        #2;
        // {ready,busy,done,s,i0,i1,y0,y1,err}
        chk("reset_outs", 32'({ready, busy, done, s, i0, i1, y0, y1, err}), 32'h100);

        // Release reset mid-cycle; accept on the very next edge (edge 0)
        @(posedge clock); #1;
        reset = 1'b0;
        load = 1'b1; d0 = 1'b1; d1 = 1'b0;
        cyc = 0;
        n_done = 0;
        step();
        load = 1'b0;
        chk("first_accept_busy", 32'(busy), 32'd1);

        // Run 1 (1,0) with queued run 2 (0,1) at edge 3, ignored load at edge 4
        while (cyc <= 30) begin
            if (cyc == 3) begin load = 1'b1; d0 = 1'b0; d1 = 1'b1; end
            if (cyc == 4) begin
                chk("ready_pend_full", 32'(ready), 32'd0);
                load = 1'b1; d0 = 1'b1; d1 = 1'b1;
            end
            if (cyc == 5) load = 1'b0;
            if ((cyc >= 1 && cyc <= 10) || (cyc >= 12 && cyc <= 21)) begin
                exp_s = ((cyc >= 6 && cyc <= 10) || (cyc >= 17)) ? 1'b1 : 1'b0;
                chk($sformatf("s_c%0d", cyc), 32'(s), 32'(exp_s));
            end
            if (cyc <= 23) begin
                chk($sformatf("done_c%0d", cyc), 32'(done), 32'((cyc == 11) || (cyc == 22)));
                chk($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc <= 22));
            end
            if (cyc == 11) chk("run1_y0y1err", 32'({y0, y1, err}), 32'b100);
            if (cyc == 12) chk("run2_i0i1_ready", 32'({i0, i1, ready}), 32'b011);
            if (cyc == 22) chk("run2_y0y1err", 32'({y0, y1, err}), 32'b010);
            if (done) n_done++;
            step();
        end
        chk("done_pulses", 32'(n_done), 32'd2);

        // Stuck-at-0 mux output: both captures are 0, err flags d0=d1=1
        tie0 = 1'b1;
        load = 1'b1; d0 = 1'b1; d1 = 1'b1;
        step();
        load = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("stuck_latency", 32'(lat), 32'd11);
        chk("stuck_y0y1err", 32'({y0, y1, err}), 32'b001);
        step();
        tie0 = 1'b0;

        // Reset at cycle 7 of a run with a pending entry
        cyc = 0;
        load = 1'b1; d0 = 1'b1; d1 = 1'b1;
        step();
        load = 1'b0;
        while (cyc < 7) begin
            if (cyc == 3) begin load = 1'b1; d0 = 1'b0; d1 = 1'b0; end
            if (cyc == 4) load = 1'b0;
            step();
        end
        chk("pre_reset_busy_ready_y0", 32'({busy, ready, y0}), 32'b101);
        #2;
        reset = 1'b1;
        #1;
        chk("midrun_reset_outs", 32'({ready, busy, done, s, i0, i1, y0, y1, err}), 32'h100);
        step();
        step();
        reset = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            step();
        end
        chk("post_reset_no_done", 32'(n_done), 32'd0);
        chk("post_reset_no_busy", 32'(n_busy), 32'd0);

        // DWELL=1 instance: s=0 in cycle 1, s=1 in cycle 2, done in cycle 3
        load_1 = 1'b1; d0_1 = 1'b1; d1_1 = 1'b0;
        step();
        load_1 = 1'b0;
        chk("d1_c1_s_busy_done", 32'({s_1, busy_1, done_1}), 32'b010);
        step();
        chk("d1_c2_s_done", 32'({s_1, done_1}), 32'b10);
        step();
        chk("d1_c3_done_y0y1err", 32'({done_1, y0_1, y1_1, err_1}), 32'b1100);
        step();
        chk("d1_c4_idle", 32'({busy_1, done_1, ready_1}), 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
